ysyx_mem_arbiter: RTL
=====================

Name: ysyx_mem_arbiter

Overview:
- Shares the single core memory port between the IFU (instruction fetch, read-only) and the LSU (load/store).
- Sits between both requesters and the bus/xbar.
- Grants one transaction at a time and latches the winner's address, strobe and data into registered downstream outputs.
- Routes the response back to the owner only, and bounds every transaction with a timeout.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_STARVE, 4, consecutive LSU grants allowed while IFU is pending before IFU is forced to win
- TIMEOUT, 255, cycles a downstream transaction may stay outstanding before it is aborted

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ifu_araddr  in  ADDR_W  fetch address
- ifu_arvalid  in  1  fetch request; held until ifu_rvalid
- ifu_rdata  out  DATA_W  fetch data
- ifu_rvalid  out  1  fetch response, 1-cycle pulse
- lsu_araddr  in  ADDR_W  load address
- lsu_arvalid  in  1  load request
- lsu_rstrb  in  8  load byte strobe
- lsu_rdata  out  DATA_W  load data
- lsu_rvalid  out  1  load response, 1-cycle pulse
- lsu_awaddr  in  ADDR_W  store address
- lsu_awvalid  in  1  store address valid
- lsu_wdata  in  DATA_W  store data
- lsu_wstrb  in  8  store byte strobe
- lsu_wvalid  in  1  store data valid
- lsu_wready  out  1  store done, 1-cycle pulse
- bus_araddr  out  ADDR_W  registered read address
- bus_arvalid  out  1  registered read request
- bus_rstrb  out  8  registered read strobe
- bus_rdata  in  DATA_W  read data
- bus_rvalid  in  1  read response
- bus_awaddr  out  ADDR_W  registered write address
- bus_awvalid  out  1  registered write request
- bus_wdata  out  DATA_W  registered write data
- bus_wstrb  out  8  registered write strobe
- bus_wvalid  out  1  registered write data valid
- bus_wready  in  1  write response
- err_o  out  1  timeout abort, 1-cycle pulse
- owner_o  out  2  current state, for debug/perf counters

Behaviour:
- Reset: state IDLE. All bus_* outputs 0, all response outputs 0, err_o 0, starve_cnt 0, timeout counter 0.
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR. owner_o encoding is 0/1/2/3 in that order.
- IDLE arbitration, evaluated each cycle, first match wins:
  1. ifu_arvalid and starve_cnt==MAX_STARVE -> IFU_RD
  2. lsu_awvalid and lsu_wvalid -> LSU_WR
  3. lsu_arvalid -> LSU_RD
  4. ifu_arvalid -> IFU_RD
- A store asserting only one of lsu_awvalid/lsu_wvalid is not granted.
- If the LSU asserts both a load and a store in the same cycle, the store wins.
- starve_cnt:
  - increments on each LSU grant while ifu_arvalid=1
  - clears on an IFU grant, and on an LSU grant while ifu_arvalid=0
  - saturates at MAX_STARVE
- On grant, the winner's address/strobe/data are captured into the bus_* registers and the matching valid(s) rise in the next cycle. Request-to-bus latency is 1 cycle from the IDLE grant cycle.
- Captured values are held stable until completion. Requester inputs changing or dropping after grant are ignored.
- Completion:
  - IFU_RD/LSU_RD: on bus_rvalid, the owner's rvalid pulses in that same cycle (combinational) and its rdata = bus_rdata.
  - LSU_WR: on bus_wready, lsu_wready pulses in that same cycle.
  - In the completion cycle, bus valids clear at the next edge and the FSM returns to IDLE.
  - The earliest next grant is the following cycle, so back-to-back transactions have a 1-cycle bubble.
- The non-owner's rvalid/wready are never asserted, and its rdata is 0.
- bus_rvalid or bus_wready arriving in IDLE, or not matching the current state, is ignored.
- Timeout:
  - The counter runs in any non-IDLE state and resets on grant.
  - When it reaches TIMEOUT with no response: bus valids drop, err_o pulses, the owner's rvalid/wready pulses with rdata=0, and the FSM returns to IDLE. All of this happens in the same cycle.
  - A response arriving in the same cycle as expiry counts as a normal completion, with no err_o.
- rst asserted mid-transaction returns the FSM to IDLE immediately and clears all outputs. No response is delivered.

Decomposition:
- Shared package/macro header (ysyx_macro.v):
  - state encodings ysyx_ARB_IDLE/IFU_RD/LSU_RD/LSU_WR
  - strobe constants 8'h1/8'h3/8'hf
- Sub-module ysyx_arb_timer: loadable down-counter, inputs clear/enable, output expire. It is reusable by the IFU and LSU wait paths.
- The FSM and datapath registers stay in this module.

Test Plan:
- Single fetch: ifu_arvalid, addr 0x8000_0000; bus_rvalid 3 cycles later with 0x0000_0413 -> bus_arvalid rises the cycle after the request, ifu_rvalid pulses once with 0x0000_0413, lsu_rvalid stays 0.
- Collision: IFU read 0x8000_0004 and LSU store 0x8000_1000 (wdata 0xdeadbeef, wstrb 8'hf) in the same cycle -> store issued first with bus_wstrb 8'hf; IFU read granted in the cycle after lsu_wready.
- Starvation: ifu_arvalid held while the LSU issues 6 back-to-back loads, MAX_STARVE=4 -> IFU granted after exactly 4 LSU grants, then the LSU resumes.
- Timeout: LSU load 0xa000_0000 with no bus_rvalid, TIMEOUT=255 -> err_o and lsu_rvalid pulse together at cycle 255 after grant, lsu_rdata=0, FSM back in IDLE.
- Reset mid-op: rst asserted while in LSU_WR before bus_wready -> bus_awvalid/bus_wvalid fall asynchronously, lsu_wready never pulses, owner_o=0.
- Stray response: bus_rvalid pulse while in IDLE -> no rvalid to either requester, no state change.

Source files
------------

// File: rtl/ysyx_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// owner_o exposes the raw state encoding, so the enum values are fixed.
package ysyx_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIfuRd = 2'd1,
    StLsuRd = 2'd2,
    StLsuWr = 2'd3
  } arb_state_e;

  localparam logic [7:0] StrbByte = 8'h01;
  localparam logic [7:0] StrbHalf = 8'h03;
  localparam logic [7:0] StrbWord = 8'h0f;

endpackage

// File: rtl/ysyx_arb_timer.sv
// Loadable down-counter that bounds how long a transaction may wait for a response.
// expire_o is high while enabled and the count has run out.
module ysyx_arb_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [Width-1:0] load_i,
  output logic             expire_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = load_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && (count_q == '0);

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Shares the core memory port between IFU fetches and LSU loads/stores, one transaction
// at a time, with registered bus requests, owner-only responses and a timeout abort.
module ysyx_mem_arbiter
  import ysyx_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic [ADDR_W-1:0] bus_araddr,
  output logic              bus_arvalid,
  output logic [7:0]        bus_rstrb,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic [ADDR_W-1:0] bus_awaddr,
  output logic              bus_awvalid,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [7:0]        bus_wstrb,
  output logic              bus_wvalid,
  input  logic              bus_wready,
  output logic              err_o,
  output logic [1:0]        owner_o
);

  localparam int unsigned StarveW = $clog2(MAX_STARVE + 1);
  localparam int unsigned TimerW  = $clog2(TIMEOUT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(MAX_STARVE);
  // Grant edge loads TIMEOUT-1 so expiry lands TIMEOUT cycles after the grant cycle.
  localparam logic [TimerW-1:0]  TimerLoad = TimerW'(TIMEOUT - 1);

  arb_state_e state_d, state_q;
  logic [StarveW-1:0] starve_d, starve_q;

  logic [ADDR_W-1:0] bus_araddr_d, bus_araddr_q;
  logic              bus_arvalid_d, bus_arvalid_q;
  logic [7:0]        bus_rstrb_d, bus_rstrb_q;
  logic [ADDR_W-1:0] bus_awaddr_d, bus_awaddr_q;
  logic              bus_awvalid_d, bus_awvalid_q;
  logic [DATA_W-1:0] bus_wdata_d, bus_wdata_q;
  logic [7:0]        bus_wstrb_d, bus_wstrb_q;
  logic              bus_wvalid_d, bus_wvalid_q;

  logic grant, done, expire, resp_hit;

  ysyx_arb_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (grant),
    .enable_i(state_q != StIdle),
    .load_i  (TimerLoad),
    .expire_o(expire)
  );

  // Only a response matching the current transaction type counts.
  assign resp_hit = (((state_q == StIfuRd) || (state_q == StLsuRd)) && bus_rvalid) ||
                    ((state_q == StLsuWr) && bus_wready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ifu_arvalid && (starve_q == StarveMax)) begin
          state_d = StIfuRd;
        end else if (lsu_awvalid && lsu_wvalid) begin
          state_d = StLsuWr;
        end else if (lsu_arvalid) begin
          state_d = StLsuRd;
        end else if (ifu_arvalid) begin
          state_d = StIfuRd;
        end
      end
      StIfuRd, StLsuRd, StLsuWr: begin
        if (resp_hit || expire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign grant = (state_q == StIdle) && (state_d != StIdle);
  assign done  = (state_q != StIdle) && (state_d == StIdle);

  always_comb begin
    starve_d = starve_q;
    if (grant) begin
      if ((state_d == StIfuRd) || !ifu_arvalid) begin
        starve_d = '0;
      end else if (starve_q != StarveMax) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_comb begin
    bus_araddr_d  = bus_araddr_q;
    bus_arvalid_d = bus_arvalid_q;
    bus_rstrb_d   = bus_rstrb_q;
    bus_awaddr_d  = bus_awaddr_q;
    bus_awvalid_d = bus_awvalid_q;
    bus_wdata_d   = bus_wdata_q;
    bus_wstrb_d   = bus_wstrb_q;
    bus_wvalid_d  = bus_wvalid_q;
    if (grant) begin
      if (state_d == StIfuRd) begin
        bus_araddr_d  = ifu_araddr;
        bus_rstrb_d   = StrbWord;
        bus_arvalid_d = 1'b1;
      end else if (state_d == StLsuRd) begin
        bus_araddr_d  = lsu_araddr;
        bus_rstrb_d   = lsu_rstrb;
        bus_arvalid_d = 1'b1;
      end else begin
        bus_awaddr_d  = lsu_awaddr;
        bus_wdata_d   = lsu_wdata;
        bus_wstrb_d   = lsu_wstrb;
        bus_awvalid_d = 1'b1;
        bus_wvalid_d  = 1'b1;
      end
    end else if (done) begin
      bus_arvalid_d = 1'b0;
      bus_awvalid_d = 1'b0;
      bus_wvalid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q      <= '0;
      bus_araddr_q  <= '0;
      bus_arvalid_q <= 1'b0;
      bus_rstrb_q   <= '0;
      bus_awaddr_q  <= '0;
      bus_awvalid_q <= 1'b0;
      bus_wdata_q   <= '0;
      bus_wstrb_q   <= '0;
      bus_wvalid_q  <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      bus_araddr_q  <= bus_araddr_d;
      bus_arvalid_q <= bus_arvalid_d;
      bus_rstrb_q   <= bus_rstrb_d;
      bus_awaddr_q  <= bus_awaddr_d;
      bus_awvalid_q <= bus_awvalid_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_wstrb_q   <= bus_wstrb_d;
      bus_wvalid_q  <= bus_wvalid_d;
    end
  end

  // A timeout still hands the owner a response, with zero data, so it never hangs.
  always_comb begin
    ifu_rvalid = (state_q == StIfuRd) && (bus_rvalid || expire);
    ifu_rdata  = ((state_q == StIfuRd) && bus_rvalid) ? bus_rdata : '0;
    lsu_rvalid = (state_q == StLsuRd) && (bus_rvalid || expire);
    lsu_rdata  = ((state_q == StLsuRd) && bus_rvalid) ? bus_rdata : '0;
    lsu_wready = (state_q == StLsuWr) && (bus_wready || expire);
    err_o      = expire && !resp_hit;
    owner_o    = state_q;
  end

  assign bus_araddr  = bus_araddr_q;
  assign bus_arvalid = bus_arvalid_q;
  assign bus_rstrb   = bus_rstrb_q;
  assign bus_awaddr  = bus_awaddr_q;
  assign bus_awvalid = bus_awvalid_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_wstrb   = bus_wstrb_q;
  assign bus_wvalid  = bus_wvalid_q;

endmodule
